sample_checker: RTL and testbench

Synthesizable on-chip counterpart of the simulation read/check/log flow. Divides the DUT clock down to the sample rate and captures the DUT output word on each sample strobe. Compares each capture against an expected-data stream and queues the tagged result in a log FIFO for a downstream reader. Keeps a sticky pass/fail flag and an error count, so that self-checking test vectors run in hardware the same way they run in simulation.

---
 rtl/sample_checker_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/sample_checker.sv | 160 ++++++++++++++++
 tb/tb_sample_checker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_checker_pkg.sv
// Shared types and elaboration helpers for the hardware sample checker.
// No logic of its own; pure declarations and constant functions.
// Not applicable: nothing here carries a handshake.
package sample_checker_pkg;

  // Top-level control states: waiting, sampling, flushing the log.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Clock divide ratio from the DUT clock to the sample rate.
  // A zero sample rate yields 0 so the top-level range check trips.
  function automatic int calc_div(input int dut_freq, input int sample_freq);
    if (sample_freq <= 0) begin
      return 0;
    end
    return dut_freq / sample_freq;
  endfunction

  // True when the two frequencies give a usable integer divide ratio.
  function automatic bit div_is_valid(input int dut_freq, input int sample_freq);
    if (sample_freq <= 0) begin
      return 1'b0;
    end
    return ((dut_freq % sample_freq) == 0) && (calc_div(dut_freq, sample_freq) >= 2);
  endfunction

  // True for powers of two that are at least 2.
  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO with a single clock.
// Latency: an entry is visible on rd_data the cycle after it is pushed into an empty FIFO.
// Backpressure: a push when full is ignored unless a pop happens in the same cycle.
module sync_fifo
  import sample_checker_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the head slot this cycle, so a push into a full FIFO may proceed.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next-pointer arithmetic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/sample_checker.sv
// Samples the DUT output at a divided rate, checks it against an expected stream and logs the result.
// Latency: strobe every DIV cycles in RUN; flags update on the strobe-closing edge; log entry visible one cycle later.
// Backpressure: log stream is valid/ready; a strobe into a full, non-popping log drops the entry and sets overflow.
module sample_checker
  import sample_checker_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int DUT_CLK_FREQ  = 100_000_000,
  parameter int SAMPLE_FREQ   = 1_000_000,
  parameter int FIFO_DEPTH    = 16,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [DATA_WIDTH-1:0]    actual,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [DATA_WIDTH-1:0]    exp_data,
  output logic                     sample_stb,
  output logic                     log_valid,
  input  logic                     log_ready,
  output logic [DATA_WIDTH-1:0]    log_data,
  output logic                     log_mismatch,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     test_passed,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     done
);

  localparam int DIV   = calc_div(DUT_CLK_FREQ, SAMPLE_FREQ);
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam int LOG_W = DATA_WIDTH + 1;

  if (!div_is_valid(DUT_CLK_FREQ, SAMPLE_FREQ)) begin : g_bad_div
    $error("sample_checker: DUT_CLK_FREQ must be an integer multiple (>= 2) of SAMPLE_FREQ");
  end

  // One log record: the captured word tagged with its check result.
  typedef struct packed {
    logic                  mismatch;
    logic [DATA_WIDTH-1:0] data;
  } log_entry_t;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     passed_q, passed_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;

  logic       mismatch;
  logic       stb_err;
  logic       log_pop;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;
  log_entry_t push_entry;
  log_entry_t head_entry;

  // Strobe on the last divider count; the expected word is consumed on the same cycle.
  assign sample_stb = (state_q == RUN) && (cnt_q == CNT_LAST);
  assign exp_ready  = sample_stb;

  // A missing expected word counts as a mismatch.
  assign mismatch = !exp_valid || (actual != exp_data);
  assign stb_err  = sample_stb && mismatch;

  assign push_entry.mismatch = mismatch;
  assign push_entry.data     = actual;

  assign log_valid    = !fifo_empty;
  assign log_pop      = log_valid && log_ready;
  assign log_data     = head_entry.data;
  assign log_mismatch = head_entry.mismatch;

  // The entry is lost only when the log is full and nothing leaves this cycle.
  assign drop = sample_stb && fifo_full && !log_pop;

  // Drain finishes the cycle the log is seen empty; that cycle also returns to IDLE.
  assign done = (state_q == DRAIN) && fifo_empty;

  assign err_count   = err_cnt_q;
  assign test_passed = passed_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  // Run/drain control; enable is only looked at in IDLE and RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)     state_d = RUN;
      RUN:     if (!enable)    state_d = DRAIN;
      DRAIN:   if (fifo_empty) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Divider counts only in RUN and sits at zero otherwise, so every RUN entry starts fresh.
  always_comb begin
    cnt_d = '0;
    if (state_q == RUN) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Result accounting for the current strobe; dropped entries still count.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (stb_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
    passed_d = passed_q && !stb_err;
    ovf_d    = ovf_q || drop;
    unf_d    = unf_q || (sample_stb && !exp_valid);
  end

  // FSM and divider registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sticky result registers; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      passed_q  <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      passed_q  <= passed_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  sync_fifo #(
    .WIDTH (LOG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_log_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (sample_stb),
    .wr_data (push_entry),
    .pop     (log_pop),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_sample_checker.sv
// Directed bench for sample_checker with DIV = 4 and a 4-entry log.
// Stimulus pushes hand-computed log entries into a scoreboard; a monitor pops them as the DUT emits them.
module tb_sample_checker;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] actual;
  logic        exp_valid;
  logic        exp_ready;
  logic [15:0] exp_data;
  logic        sample_stb;
  logic        log_valid;
  logic        log_ready;
  logic [15:0] log_data;
  logic        log_mismatch;
  logic [15:0] err_count;
  logic        test_passed;
  logic        overflow;
  logic        underflow;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [16:0] sb_q[$];

  sample_checker #(
    .DATA_WIDTH    (16),
    .DUT_CLK_FREQ  (4_000_000),
    .SAMPLE_FREQ   (1_000_000),
    .FIFO_DEPTH    (4),
    .ERR_CNT_WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .actual       (actual),
    .exp_valid    (exp_valid),
    .exp_ready    (exp_ready),
    .exp_data     (exp_data),
    .sample_stb   (sample_stb),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_data     (log_data),
    .log_mismatch (log_mismatch),
    .err_count    (err_count),
    .test_passed  (test_passed),
    .overflow     (overflow),
    .underflow    (underflow),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Apply one sample vector, wait for its strobe and check the gap in negedges.
  task automatic strobe(input logic [15:0] act, input logic [15:0] expd, input logic ev,
                        input logic mis, input int gap, input logic logged);
    int   n;
    logic got;
    enable    = 1'b1;
    actual    = act;
    exp_data  = expd;
    exp_valid = ev;
    n   = 0;
    got = 1'b0;
    while (!got && n < 16) begin
      @(negedge clk);
      n++;
      got = sample_stb;
      if (!got) chk("exp_ready_idle", {31'd0, exp_ready}, 32'd0);
    end
    chk("stb_gap", n, gap);
    chk("exp_ready_stb", {31'd0, exp_ready}, 32'd1);
    if (logged) sb_q.push_back({mis, act});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic [15:0] e_err, input logic e_pass,
                           input logic e_ovf, input logic e_unf);
    chk({tag, "_err_count"}, {16'd0, err_count}, {16'd0, e_err});
    chk({tag, "_test_passed"}, {31'd0, test_passed}, {31'd0, e_pass});
    chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, e_ovf});
    chk({tag, "_underflow"}, {31'd0, underflow}, {31'd0, e_unf});
  endtask

  // Monitor: scoreboard pops on every log handshake, plus hold checks under stall.
  initial begin : monitor
    logic        stall;
    logic [16:0] held;
    logic [16:0] want;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("log_hold_valid", {31'd0, log_valid}, 32'd1);
          chk("log_hold_entry", {15'd0, log_mismatch, log_data}, {15'd0, held});
        end
        if (log_valid && log_ready) begin
          if (sb_q.size() == 0) begin
            chk("log_unexpected_pop", sb_q.size(), 32'd1);
          end else begin
            want = sb_q.pop_front();
            chk("log_entry", {15'd0, log_mismatch, log_data}, {15'd0, want});
          end
        end
        stall = log_valid && !log_ready;
        held  = {log_mismatch, log_data};
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int done_n;
    int stb_n;
    int lv_n;
    rst_n     = 1'b0;
    enable    = 1'b0;
    actual    = '0;
    exp_data  = '0;
    exp_valid = 1'b0;
    log_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_flags("rst_hold", 16'd0, 1'b1, 1'b0, 1'b0);
    chk("rst_log_valid", {31'd0, log_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_flags("rst_rel", 16'd0, 1'b1, 1'b0, 1'b0);
    chk("rst_stb", {31'd0, sample_stb}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // Eight matching samples; first strobe lands in the 4th RUN cycle.
    for (int i = 0; i < 8; i++) begin
      strobe(16'h1234, 16'h1234, 1'b1, 1'b0, (i == 0) ? 5 : 4, 1'b1);
    end
    chk_flags("match8", 16'd0, 1'b1, 1'b0, 1'b0);

    // Third strobe of this group mismatches; test_passed must stay low afterwards.
    strobe(16'h1111, 16'h1111, 1'b1, 1'b0, 4, 1'b1);
    strobe(16'h2222, 16'h2222, 1'b1, 1'b0, 4, 1'b1);
    strobe(16'h00FF, 16'h00FE, 1'b1, 1'b1, 4, 1'b1);
    chk_flags("mis1", 16'd1, 1'b0, 1'b0, 1'b0);
    strobe(16'h3333, 16'h3333, 1'b1, 1'b0, 4, 1'b1);
    chk_flags("mis1_after", 16'd1, 1'b0, 1'b0, 1'b0);

    // Let the last entry drain, then stall the log across six strobes.
    @(posedge clk);
    #1;
    log_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      strobe(16'hA000 + 16'(i), 16'hA000 + 16'(i), 1'b1, 1'b0, (i == 0) ? 3 : 4, i < 4);
      if (i == 3) chk("ovf_before_full", {31'd0, overflow}, 32'd0);
    end
    chk_flags("ovf", 16'd1, 1'b0, 1'b1, 1'b0);

    // Expected word missing: forced mismatch even though data would have matched.
    log_ready = 1'b1;
    strobe(16'h5555, 16'h5555, 1'b0, 1'b1, 4, 1'b1);
    chk_flags("unf", 16'd2, 1'b0, 1'b1, 1'b1);

    // Queue three entries, drop enable, then release the log.
    @(posedge clk);
    #1;
    log_ready = 1'b0;
    strobe(16'h0101, 16'h0101, 1'b1, 1'b0, 3, 1'b1);
    strobe(16'h0202, 16'h0202, 1'b1, 1'b0, 4, 1'b1);
    strobe(16'h0303, 16'h0303, 1'b1, 1'b0, 4, 1'b1);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    log_ready = 1'b1;
    done_n = 0;
    stb_n  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_n++;
      if (sample_stb) stb_n++;
    end
    chk("drain_done_pulses", done_n, 32'd1);
    chk("drain_no_stb", stb_n, 32'd0);
    chk("drain_sb_empty", sb_q.size(), 32'd0);
    chk("drain_log_valid", {31'd0, log_valid}, 32'd0);

    // Back in IDLE: re-enable restarts the divider; then reset mid-drain.
    @(posedge clk);
    #1;
    log_ready = 1'b0;
    strobe(16'h0A0A, 16'h0A0A, 1'b1, 1'b0, 5, 1'b0);
    strobe(16'h0B0B, 16'h0B0B, 1'b1, 1'b0, 4, 1'b0);
    strobe(16'h0C0C, 16'h0C0C, 1'b1, 1'b0, 4, 1'b0);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("predrain_log_valid", {31'd0, log_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_flags("mid_rst", 16'd0, 1'b1, 1'b0, 1'b0);
    chk("mid_rst_log_valid", {31'd0, log_valid}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_exp_ready", {31'd0, exp_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    log_ready = 1'b1;
    done_n = 0;
    lv_n   = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_n++;
      if (log_valid) lv_n++;
    end
    chk("post_rst_done", done_n, 32'd0);
    chk("post_rst_log_valid", lv_n, 32'd0);
    chk("final_sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
